// File: rtl/udp_slicer_pkg.sv
// rtl/udp_slicer_pkg.sv - shared states, word size and word-count helper for the JPEG UDP slicer
package udp_slicer_pkg;

    localparam int WORD_BYTES = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREFETCH = 3'd1;
    localparam logic [2:0] ST_LAUNCH   = 3'd2;
    localparam logic [2:0] ST_SENDING  = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Number of 128-bit words needed to carry nbytes; 17 bits so the +15 never overflows.
    function automatic logic [16:0] calc_words(input logic [15:0] nbytes);
        return ({1'b0, nbytes} + 17'(WORD_BYTES - 1)) / 17'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/udp_slicer_rd_ctrl.sv
// rtl/udp_slicer_rd_ctrl.sv - single-outstanding DDR3 word reader with output word and 1-entry buffer
module udp_slicer_rd_ctrl
#(
    parameter int ADDR_W    = 28,
    parameter int ADDR_STEP = 8
) (
    input  logic              i_udp_clk50m,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [16:0]       start_words,
    input  logic              consume,
    input  logic              flush,
    output logic              out_loaded,
    output logic              buf_valid,
    output logic [127:0]      out_word,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [127:0]      rd_data
);
    import udp_slicer_pkg::*;

    logic [16:0]       left;
    logic [ADDR_W-1:0] next_addr;
    logic              wait_valid;
    logic              dest_out;
    logic [127:0]      buf_word;
    logic              can_issue;

    // A new read goes out only when nothing is in flight and its destination slot is free.
    assign can_issue = !rd_req && !wait_valid && (left != 17'd0) && (dest_out || !buf_valid);

    // Read engine: word 0 of a packet lands in the output word, later words in the buffer.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left       <= '0;
            next_addr  <= '0;
            wait_valid <= 1'b0;
            dest_out   <= 1'b0;
            buf_word   <= '0;
            buf_valid  <= 1'b0;
            out_word   <= '0;
            out_loaded <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
        end else begin
            out_loaded <= 1'b0;
            if (flush) begin
                rd_req     <= 1'b0;
                wait_valid <= 1'b0;
                buf_valid  <= 1'b0;
                dest_out   <= 1'b0;
                left       <= '0;
            end else if (start) begin
                left      <= start_words;
                next_addr <= start_addr;
                dest_out  <= 1'b1;
            end else begin
                if (rd_req && rd_ack) begin
                    rd_req     <= 1'b0;
                    wait_valid <= 1'b1;
                end
                if (wait_valid && rd_valid) begin
                    wait_valid <= 1'b0;
                    if (dest_out) begin
                        out_word   <= rd_data;
                        out_loaded <= 1'b1;
                        dest_out   <= 1'b0;
                    end else begin
                        buf_word  <= rd_data;
                        buf_valid <= 1'b1;
                    end
                end
                if (consume && buf_valid) begin
                    out_word  <= buf_word;
                    buf_valid <= 1'b0;
                end
                if (can_issue) begin
                    rd_req    <= 1'b1;
                    rd_addr   <= next_addr;
                    next_addr <= next_addr + ADDR_W'(ADDR_STEP);
                    left      <= left - 17'd1;
                end
            end
        end
    end

endmodule

// File: rtl/udp_jpeg_slicer.sv
// rtl/udp_jpeg_slicer.sv - cuts a DDR3-resident MJPEG frame into UDP payloads for the 128-bit sender
module udp_jpeg_slicer
#(
    parameter int MAX_PAYLOAD = 1024,
    parameter int ADDR_W      = 28,
    parameter int ADDR_STEP   = 8,
    parameter int GAP_CYCLES  = 64
) (
    input  logic              i_udp_clk50m,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic [23:0]       i_frame_len,
    input  logic [ADDR_W-1:0] i_frame_base_addr,
    output logic              o_ready,
    output logic              o_frame_done,
    output logic              o_underrun,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [127:0]      i_rd_data,
    output logic              o_en,
    output logic [127:0]      o_wrdata,
    output logic              o_last_frame_flag,
    output logic [14:0]       o_frame_rank,
    output logic [15:0]       o_jpeg_len,
    output logic [15:0]       o_ipv4_sign,
    input  logic              i_data_upd_req,
    input  logic              i_busy
);
    import udp_slicer_pkg::*;

    logic [2:0]        state;
    logic [23:0]       remaining;
    logic [ADDR_W-1:0] addr;
    logic [14:0]       rank_cnt;
    logic [16:0]       words;
    logic [15:0]       gap_cnt;
    logic              seen_busy;
    logic              upd_d;

    logic              upd_rise;
    logic              start_ok;
    logic              gap_done;
    logic              pkt_entry;
    logic              send_exit;
    logic              consume;
    logic              out_loaded;
    logic              buf_valid;

    logic [23:0]       entry_rem;
    logic [ADDR_W-1:0] entry_addr;
    logic              entry_last;
    logic [15:0]       entry_len;
    logic [16:0]       entry_words;

    assign upd_rise  = i_data_upd_req && !upd_d;
    assign start_ok  = (state == ST_IDLE) && i_frame_start && (i_frame_len != 24'd0);
    assign gap_done  = (state == ST_GAP) && (gap_cnt == 16'(GAP_CYCLES - 1));
    assign pkt_entry = start_ok || gap_done;
    assign send_exit = (state == ST_SENDING) && seen_busy && !i_busy;
    assign consume   = (state == ST_SENDING) && upd_rise;

    assign o_ready      = (state == ST_IDLE);
    assign o_en         = (state == ST_LAUNCH);
    assign o_frame_done = (state == ST_DONE);

    // Per-packet values; on a fresh frame they come straight from the start inputs.
    always_comb begin
        entry_rem   = (state == ST_IDLE) ? i_frame_len : remaining;
        entry_addr  = (state == ST_IDLE) ? i_frame_base_addr : addr;
        entry_last  = (entry_rem <= 24'(MAX_PAYLOAD));
        entry_len   = entry_last ? entry_rem[15:0] : 16'(MAX_PAYLOAD);
        entry_words = calc_words(entry_len);
    end

    udp_slicer_rd_ctrl #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_rd_ctrl (
        .i_udp_clk50m (i_udp_clk50m),
        .i_rst_n      (i_rst_n),
        .start        (pkt_entry),
        .start_addr   (entry_addr),
        .start_words  (entry_words),
        .consume      (consume),
        .flush        (send_exit),
        .out_loaded   (out_loaded),
        .buf_valid    (buf_valid),
        .out_word     (o_wrdata),
        .rd_req       (o_rd_req),
        .rd_addr      (o_rd_addr),
        .rd_ack       (i_rd_ack),
        .rd_valid     (i_rd_valid),
        .rd_data      (i_rd_data)
    );

    // Packet sequencer: frame bookkeeping, sender handshake and inter-packet gap.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            remaining         <= '0;
            addr              <= '0;
            rank_cnt          <= '0;
            words             <= '0;
            gap_cnt           <= '0;
            seen_busy         <= 1'b0;
            upd_d             <= 1'b0;
            o_underrun        <= 1'b0;
            o_last_frame_flag <= 1'b0;
            o_frame_rank      <= '0;
            o_jpeg_len        <= '0;
            o_ipv4_sign       <= '0;
        end else begin
            upd_d <= i_data_upd_req;
            if (consume && !buf_valid) begin
                o_underrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        remaining <= i_frame_len;
                        addr      <= i_frame_base_addr;
                        rank_cnt  <= '0;
                        state     <= ST_PREFETCH;
                    end
                end
                ST_PREFETCH: begin
                    if (out_loaded) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_SENDING;
                end
                ST_SENDING: begin
                    if (i_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (send_exit) begin
                        remaining   <= remaining - {8'd0, o_jpeg_len};
                        addr        <= addr + ADDR_W'(words) * ADDR_W'(ADDR_STEP);
                        rank_cnt    <= rank_cnt + 15'd1;
                        o_ipv4_sign <= o_ipv4_sign + 16'd1;
                        gap_cnt     <= '0;
                        state       <= o_last_frame_flag ? ST_DONE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state <= ST_PREFETCH;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (pkt_entry) begin
                o_jpeg_len        <= entry_len;
                o_last_frame_flag <= entry_last;
                o_frame_rank      <= start_ok ? 15'd0 : rank_cnt;
                words             <= entry_words;
                seen_busy         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_jpeg_slicer.sv
// tb/tb_udp_jpeg_slicer.sv - directed self-checking bench for udp_jpeg_slicer
module tb_udp_jpeg_slicer;

    localparam int P = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic [23:0]  frame_len = '0;
    logic [27:0]  base = '0;
    logic         rd_valid = 1'b0;
    logic [127:0] rd_data = '0;
    logic         upd = 1'b0;
    logic         busy = 1'b0;
    logic         rd_ack;

    logic         o_ready, o_frame_done, o_underrun, o_rd_req, o_en, o_last_frame_flag;
    logic [27:0]  o_rd_addr;
    logic [127:0] o_wrdata;
    logic [14:0]  o_frame_rank;
    logic [15:0]  o_jpeg_len, o_ipv4_sign;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t_fall = 0;
    int lat = 4;
    logic ddr_flush = 1'b0;
    logic pend = 1'b0;
    int cnt = 0;
    logic [27:0] paddr = '0;
    logic [27:0] rd_log [0:1023];
    int rd_n = 0;
    int rd_mark = 0;

    assign rd_ack = o_rd_req;

    udp_jpeg_slicer dut (
        .i_udp_clk50m      (clk),
        .i_rst_n           (rst_n),
        .i_frame_start     (frame_start),
        .i_frame_len       (frame_len),
        .i_frame_base_addr (base),
        .o_ready           (o_ready),
        .o_frame_done      (o_frame_done),
        .o_underrun        (o_underrun),
        .o_rd_req          (o_rd_req),
        .o_rd_addr         (o_rd_addr),
        .i_rd_ack          (rd_ack),
        .i_rd_valid        (rd_valid),
        .i_rd_data         (rd_data),
        .o_en              (o_en),
        .o_wrdata          (o_wrdata),
        .o_last_frame_flag (o_last_frame_flag),
        .o_frame_rank      (o_frame_rank),
        .o_jpeg_len        (o_jpeg_len),
        .o_ipv4_sign       (o_ipv4_sign),
        .i_data_upd_req    (upd),
        .i_busy            (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mkdata(input logic [27:0] a);
        return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
    endfunction

    // DDR3 model: always accepts, returns address-tagged data lat cycles later
    always @(negedge clk) begin
        rd_valid = 1'b0;
        if (ddr_flush) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cnt == 0) begin
                rd_valid = 1'b1;
                rd_data  = mkdata(paddr);
                pend     = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (o_rd_req) begin
            pend  = 1'b1;
            paddr = o_rd_addr;
            cnt   = lat - 1;
            if (rd_n < 1024) rd_log[rd_n] = o_rd_addr;
            rd_n = rd_n + 1;
        end
    end

    task automatic start_frame(input logic [23:0] len, input logic [27:0] a);
        @(negedge clk);
        frame_start = 1'b1;
        frame_len   = len;
        base        = a;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Sender model for one packet; reports header fields, read count, word/address errors and gap
    task automatic send_packet(input logic [27:0] exp_base, input bit inject,
                               output bit got_en, output logic [15:0] len, output logic [14:0] rank,
                               output logic last, output logic [15:0] sign, output int nreads,
                               output int bad, output int gap);
        int t;
        int nw;
        t = 0; got_en = 0; len = '0; rank = '0; last = 1'b0; sign = '0; nreads = 0; bad = 0; gap = 0;
        while (o_en !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (o_en !== 1'b1) return;
        got_en = 1;
        gap  = cyc - t_fall;
        len  = o_jpeg_len;
        rank = o_frame_rank;
        last = o_last_frame_flag;
        sign = o_ipv4_sign;
        nw   = (int'(len) + 15) / 16;
        if (o_wrdata !== mkdata(exp_base)) bad++;
        busy = 1'b1;
        if (inject) begin
            @(negedge clk);
            frame_start = 1'b1;
            frame_len   = 24'd5000;
            base        = 28'h9000;
            @(negedge clk);
            frame_start = 1'b0;
        end
        for (int k = 1; k < nw; k++) begin
            repeat (P - 2) @(negedge clk);
            upd = 1'b1;
            @(negedge clk);
            if (o_wrdata !== mkdata(exp_base + 28'(k * 8))) bad++;
            @(negedge clk);
            upd = 1'b0;
        end
        repeat (3) @(negedge clk);
        busy   = 1'b0;
        t_fall = cyc;
        nreads = rd_n - rd_mark;
        for (int i = 0; i < nreads; i++)
            if (rd_log[rd_mark + i] !== exp_base + 28'(i * 8)) bad++;
        rd_mark = rd_n;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({o_ready, o_en, o_frame_done, o_rd_req, o_underrun, o_last_frame_flag} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags got %b want 100000", {o_ready, o_en, o_frame_done, o_rd_req, o_underrun, o_last_frame_flag});
        end
        tests++;
        if (o_wrdata !== 128'd0 || o_rd_addr !== 28'd0) begin
            fails++;
            $display("FAIL reset_data got wrdata=%h addr=%h want 0", o_wrdata, o_rd_addr);
        end
        tests++;
        if (o_frame_rank !== 15'd0 || o_jpeg_len !== 16'd0 || o_ipv4_sign !== 16'd0) begin
            fails++;
            $display("FAIL reset_hdr got rank=%0d len=%0d sign=%0d want 0", o_frame_rank, o_jpeg_len, o_ipv4_sign);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after got %b want 1", o_ready);
        end
    endtask

    task automatic test_single();
        bit g; logic [15:0] l; logic [14:0] r; logic la; logic [15:0] s; int n, b, gp, t;
        lat = 4;
        rd_mark = rd_n;
        start_frame(24'd100, 28'h100);
        send_packet(28'h100, 0, g, l, r, la, s, n, b, gp);
        tests++;
        if (g !== 1'b1) begin fails++; $display("FAIL single_en got %b want 1", g); end
        tests++;
        if (l !== 16'd100 || la !== 1'b1 || r !== 15'd0 || s !== 16'd0) begin
            fails++;
            $display("FAIL single_hdr got len=%0d last=%b rank=%0d sign=%0d want 100 1 0 0", l, la, r, s);
        end
        tests++;
        if (n !== 7 || b !== 0) begin fails++; $display("FAIL single_reads got n=%0d bad=%0d want 7 0", n, b); end
        t = 0;
        while (o_frame_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        tests++;
        if (o_frame_done !== 1'b1) begin fails++; $display("FAIL single_done got %b want 1", o_frame_done); end
        tests++;
        if (o_underrun !== 1'b0) begin fails++; $display("FAIL single_underrun got %b want 0", o_underrun); end
        @(negedge clk);
        tests++;
        if (o_ready !== 1'b1) begin fails++; $display("FAIL single_idle got %b want 1", o_ready); end
    endtask

    task automatic test_multi();
        bit g; logic [15:0] l; logic [14:0] r; logic la; logic [15:0] s; int n, b, gp, t;
        logic [15:0] exp_len [3];
        int          exp_n   [3];
        logic [27:0] exp_a   [3];
        exp_len = '{16'd1024, 16'd1024, 16'd452};
        exp_n   = '{64, 64, 29};
        exp_a   = '{28'h2000, 28'h2200, 28'h2400};
        lat = 4;
        rd_mark = rd_n;
        start_frame(24'd2500, 28'h2000);
        for (int p = 0; p < 3; p++) begin
            send_packet(exp_a[p], 0, g, l, r, la, s, n, b, gp);
            tests++;
            if (g !== 1'b1 || l !== exp_len[p] || r !== 15'(p) || la !== (p == 2)) begin
                fails++;
                $display("FAIL multi_hdr%0d got en=%b len=%0d rank=%0d last=%b want 1 %0d %0d %b", p, g, l, r, la, exp_len[p], p, p == 2);
            end
            tests++;
            if (s !== 16'(p + 1)) begin fails++; $display("FAIL multi_sign%0d got %0d want %0d", p, s, p + 1); end
            tests++;
            if (n !== exp_n[p] || b !== 0) begin
                fails++;
                $display("FAIL multi_reads%0d got n=%0d bad=%0d want %0d 0", p, n, b, exp_n[p]);
            end
            if (p > 0) begin
                tests++;
                if (gp < 65) begin fails++; $display("FAIL multi_gap%0d got %0d want >=65", p, gp); end
            end
        end
        t = 0;
        while (o_frame_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        tests++;
        if (o_frame_done !== 1'b1) begin fails++; $display("FAIL multi_done got %b want 1", o_frame_done); end
    endtask

    task automatic test_start_ignored();
        bit g; logic [15:0] l; logic [14:0] r; logic la; logic [15:0] s; int n, b, gp, t, extra_en, extra_rd, not_ready;
        lat = 4;
        repeat (5) @(negedge clk);
        rd_mark = rd_n;
        start_frame(24'd32, 28'h3000);
        send_packet(28'h3000, 1, g, l, r, la, s, n, b, gp);
        tests++;
        if (g !== 1'b1 || l !== 16'd32 || la !== 1'b1 || s !== 16'd4 || n !== 2 || b !== 0) begin
            fails++;
            $display("FAIL inject_pkt got en=%b len=%0d last=%b sign=%0d n=%0d bad=%0d want 1 32 1 4 2 0", g, l, la, s, n, b);
        end
        t = 0;
        while (o_frame_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        tests++;
        if (o_frame_done !== 1'b1) begin fails++; $display("FAIL inject_done got %b want 1", o_frame_done); end
        extra_en = 0; extra_rd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_en === 1'b1) extra_en++;
            if (o_rd_req === 1'b1) extra_rd++;
        end
        tests++;
        if (extra_en !== 0 || extra_rd !== 0) begin
            fails++;
            $display("FAIL inject_ignored got en=%0d rd=%0d want 0 0", extra_en, extra_rd);
        end
        extra_en = 0; extra_rd = 0; not_ready = 0;
        start_frame(24'd0, 28'h7000);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_en === 1'b1) extra_en++;
            if (o_rd_req === 1'b1) extra_rd++;
            if (o_ready !== 1'b1) not_ready++;
        end
        tests++;
        if (extra_en !== 0 || extra_rd !== 0 || not_ready !== 0) begin
            fails++;
            $display("FAIL zero_len got en=%0d rd=%0d notready=%0d want 0 0 0", extra_en, extra_rd, not_ready);
        end
    endtask

    task automatic test_underrun();
        bit g; logic [15:0] l; logic [14:0] r; logic la; logic [15:0] s; int n, b, gp, t;
        lat = 4;
        rd_mark = rd_n;
        start_frame(24'd64, 28'h4000);
        send_packet(28'h4000, 0, g, l, r, la, s, n, b, gp);
        repeat (30) @(negedge clk);
        tests++;
        if (g !== 1'b1 || o_underrun !== 1'b0 || b !== 0) begin
            fails++;
            $display("FAIL lat4_no_underrun got en=%b underrun=%b bad=%0d want 1 0 0", g, o_underrun, b);
        end
        lat = 12;
        rd_mark = rd_n;
        start_frame(24'd64, 28'h4400);
        send_packet(28'h4400, 0, g, l, r, la, s, n, b, gp);
        t = 0;
        while (o_frame_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (30) @(negedge clk);
        tests++;
        if (g !== 1'b1 || o_underrun !== 1'b1 || n > 4) begin
            fails++;
            $display("FAIL lat12_underrun got en=%b underrun=%b reads=%0d want 1 1 <=4", g, o_underrun, n);
        end
        lat = 4;
        rd_mark = rd_n;
        start_frame(24'd16, 28'h5000);
        send_packet(28'h5000, 0, g, l, r, la, s, n, b, gp);
        repeat (20) @(negedge clk);
        tests++;
        if (g !== 1'b1 || o_underrun !== 1'b1 || s !== 16'd7 || n !== 1) begin
            fails++;
            $display("FAIL underrun_sticky got en=%b underrun=%b sign=%0d n=%0d want 1 1 7 1", g, o_underrun, s, n);
        end
    endtask

    task automatic test_reset_mid();
        bit g; logic [15:0] l; logic [14:0] r; logic la; logic [15:0] s; int n, b, gp, t;
        lat = 4;
        rd_mark = rd_n;
        start_frame(24'd2500, 28'h6000);
        t = 0;
        while (o_en !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        tests++;
        if (o_en !== 1'b1) begin fails++; $display("FAIL mid_en got %b want 1", o_en); end
        busy = 1'b1;
        repeat (P - 2) @(negedge clk);
        upd = 1'b1;
        repeat (2) @(negedge clk);
        upd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({o_ready, o_en, o_frame_done, o_rd_req, o_underrun, o_last_frame_flag} !== 6'b100000) begin
            fails++;
            $display("FAIL mid_reset_flags got %b want 100000", {o_ready, o_en, o_frame_done, o_rd_req, o_underrun, o_last_frame_flag});
        end
        tests++;
        if (o_wrdata !== 128'd0 || o_rd_addr !== 28'd0 || o_frame_rank !== 15'd0 || o_jpeg_len !== 16'd0 || o_ipv4_sign !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset_vals got wr=%h addr=%h rank=%0d len=%0d sign=%0d want 0", o_wrdata, o_rd_addr, o_frame_rank, o_jpeg_len, o_ipv4_sign);
        end
        busy = 1'b0;
        ddr_flush = 1'b1;
        repeat (3) @(negedge clk);
        ddr_flush = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        t_fall = cyc;
        rd_mark = rd_n;
        start_frame(24'd100, 28'h300);
        send_packet(28'h300, 0, g, l, r, la, s, n, b, gp);
        tests++;
        if (g !== 1'b1 || l !== 16'd100 || r !== 15'd0 || s !== 16'd0 || n !== 7 || b !== 0) begin
            fails++;
            $display("FAIL post_reset_frame got en=%b len=%0d rank=%0d sign=%0d n=%0d bad=%0d want 1 100 0 0 7 0", g, l, r, s, n, b);
        end
        t = 0;
        while (o_frame_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        tests++;
        if (o_frame_done !== 1'b1) begin fails++; $display("FAIL post_reset_done got %b want 1", o_frame_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_start_ignored();
        test_underrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
